div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit radix-2 divider for the CPU's DIV/DIVU instructions. It sits between the execute stage and the register file's HI/LO write port. It takes operands from EX and holds the pipeline via `stallreq` while it iterates. It then drives the HI/LO write enables and data for one cycle: remainder to HI, quotient to LO.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  divide request from EX; sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1`  in  32  dividend.
- `opdata2`  in  32  divisor.
- `annul`  in  1  pipeline flush; cancels any in-flight or requested divide.
- `stallreq`  out  1  combinational pipeline stall request.
- `ready`  out  1  one-cycle result-valid pulse.
- `hi_we`  out  1  HI write enable; equals `ready`.
- `hi_data`  out  32  remainder; 0 when `hi_we`=0.
- `lo_we`  out  1  LO write enable; equals `ready`.
- `lo_data`  out  32  quotient; 0 when `lo_we`=0.

## Operation
- States: IDLE, DIVZERO, ON, END. Reset forces IDLE, clears the counter, operand, quotient and remainder registers, and drives all outputs to 0.
- **IDLE**
  - `start`=1 and `annul`=0: latch `signed_div` and the operand signs.
  - Divisor = 0: go to DIVZERO.
  - Otherwise: latch |dividend| and |divisor|, clear the 6-bit counter, go to ON. Magnitudes are two's-complement negated only when `signed_div`=1 and the operand MSB=1.
- **ON:** one restoring step per cycle on a 65-bit {remainder, dividend} shift register.
  - Shift left by 1; compute trial = upper 33 bits − {1'b0, |divisor|}.
  - If trial is non-negative, replace the upper bits with the trial and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments each step. After the 32nd step (counter = 32), go to END.
- **Sign fix-up** (combinational into the END result registers):
  - Quotient is negated when `signed_div`=1 and the operand signs differ.
  - Remainder takes the dividend's sign.
  - All arithmetic is truncated to 32 bits. Signed 0x80000000 / 0xFFFFFFFF therefore yields LO=0x80000000, HI=0.
- **DIVZERO:** load LO=0xFFFFFFFF and HI=dividend as presented (unsigned/raw bits), then go to END.
- **END:** `ready`, `hi_we` and `lo_we` are 1 with the result on `hi_data`/`lo_data`. The next state is always IDLE; `start` is ignored in END.
- **annul** in DIVZERO or ON: go to IDLE next edge, no write. `annul` in END has no effect; the write still occurs.
- **Reset mid-operation:** immediate return to IDLE, outputs 0, no write.

## Timing
- `stallreq` = (IDLE & `start` & ~`annul`) | ON | DIVZERO, each term gated by ~`annul` in DIVZERO/ON. It is 0 in END, so the instruction leaves EX on the same edge that HI/LO are written.
- **Normal divide:** accept in cycle 0, ON for cycles 1–32, END in cycle 33. HI/LO are written at the end of cycle 33; latency is 33 cycles from accept to `ready`.
- **Divide by zero:** accept in cycle 0, DIVZERO in cycle 1, END in cycle 2.
- **Back-to-back:** a new `start` is accepted in the IDLE cycle right after END, so there is a minimum 1-cycle gap between divides.
- Operands are sampled only in the accept cycle; later changes on `opdata*` are ignored.

## Test plan
- **Unsigned:** DIVU, 100 / 7, start in cycle 0 → `stallreq`=1 for cycles 0–32; `ready`=1 only in cycle 33 with LO=14, HI=2.
- **Signed mixed signs:**
  - DIV, 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV, 7 / 0xFFFFFFFE → LO=0xFFFFFFFD, HI=1.
- **Overflow:** DIV, 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; DIVU on the same operands → LO=0, HI=0x80000000.
- **Divide by zero:** DIVU, 0x1234 / 0 → `ready` in cycle 2, LO=0xFFFFFFFF, HI=0x1234, `stallreq` low in cycle 2.
- **Annul:** start 100/7, assert `annul` in cycle 10 → `stallreq`=0 in cycle 10, IDLE in cycle 11, no `hi_we`/`lo_we` through cycle 40. A following DIVU 9/4 completes with LO=2, HI=1.
- **Reset mid-op:** drop `resetn` in cycle 15 → all outputs 0 immediately. After release, no write occurs until a new `start`.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; stalls EX while iterating and
// writes the remainder to HI and the quotient to LO for one cycle in END.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  input  logic             annul,
  output logic             stallreq,
  output logic             ready,
  output logic             hi_we,
  output logic [WIDTH-1:0] hi_data,
  output logic             lo_we,
  output logic [WIDTH-1:0] lo_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_signed;
  logic                 r_sign1;
  logic                 r_sign2;
  logic [5:0]           r_cnt;
  logic [WIDTH-1:0]     r_divisor;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic [2*WIDTH:0]     w_shift;
  logic [WIDTH:0]       w_trial;
  logic [2*WIDTH-1:0]   w_step;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic                 w_last;

  assign w_accept = start & ~annul;
  assign w_mag1   = (signed_div & opdata1[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata1) : opdata1;
  assign w_mag2   = (signed_div & opdata2[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata2) : opdata2;
  assign w_last   = (r_cnt == 6'(WIDTH - 1));

  // One restoring step: the running remainder never exceeds the divisor, so the
  // upper half of the accumulator always fits WIDTH bits after restoration.
  assign w_shift = {r_acc, 1'b0};
  assign w_trial = w_shift[2*WIDTH:WIDTH] - {1'b0, r_divisor};
  assign w_step  = w_trial[WIDTH] ? w_shift[2*WIDTH-1:0]
                                  : {w_trial[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};

  assign w_quot_fix = (r_signed & (r_sign1 ^ r_sign2)) ? ({WIDTH{1'b0}} - w_step[WIDTH-1:0])
                                                       : w_step[WIDTH-1:0];
  assign w_rem_fix  = (r_signed & r_sign1) ? ({WIDTH{1'b0}} - w_step[2*WIDTH-1:WIDTH])
                                           : w_step[2*WIDTH-1:WIDTH];

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic and pipeline stall request
  always_comb begin
    w_next   = r_state;
    stallreq = 1'b0;
    case (r_state)
      S_IDLE: begin
        stallreq = w_accept;
        if (w_accept) begin
          w_next = (opdata2 == {WIDTH{1'b0}}) ? S_DIVZERO : S_ON;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DIVZERO: begin
        stallreq = ~annul;
        if (annul) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_END;
        end
      end
      S_ON: begin
        stallreq = ~annul;
        if (annul) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_END;
        end else begin
          w_next = S_ON;
        end
      end
      S_END: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result registers; results are nonzero only in END
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_cnt     <= 6'd0;
      r_divisor <= {WIDTH{1'b0}};
      r_acc     <= {2*WIDTH{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
    end else begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed  <= signed_div;
            r_sign1   <= opdata1[WIDTH-1];
            r_sign2   <= opdata2[WIDTH-1];
            r_cnt     <= 6'd0;
            r_divisor <= w_mag2;
            // A zero divisor keeps the raw dividend bits for HI
            if (opdata2 == {WIDTH{1'b0}}) begin
              r_acc <= {{WIDTH{1'b0}}, opdata1};
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_mag1};
            end
          end
        end
        S_DIVZERO: begin
          if (!annul) begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= {WIDTH{1'b1}};
          end
        end
        S_ON: begin
          if (!annul) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quot_fix;
            end
          end
        end
        S_END: begin
          r_cnt <= 6'd0;
        end
        default: begin
          r_cnt <= 6'd0;
        end
      endcase
    end
  end

  assign ready   = (r_state == S_END);
  assign hi_we   = ready;
  assign lo_we   = ready;
  assign hi_data = r_hi;
  assign lo_data = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected {HI,LO} pairs go into a scoreboard queue
// at issue and are popped when ready is seen.
module tb_div_unit;

  typedef logic [95:0] w_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        stallreq;
  logic        ready;
  logic        hi_we;
  logic [31:0] hi_data;
  logic        lo_we;
  logic [31:0] lo_data;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb[$];

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .stallreq   (stallreq),
    .ready      (ready),
    .hi_we      (hi_we),
    .hi_data    (hi_data),
    .lo_we      (lo_we),
    .lo_data    (lo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: wide signed arithmetic, truncated to 32 bits
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint la;
    longint lb;
    longint q;
    longint r;
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end
    la = sd ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
    lb = sd ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one divide in the current cycle, then scrambles operands while waiting.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [63:0] exp, input string tag);
    int          c;
    logic        found;
    logic        stall_ok;
    logic [63:0] want;
    start      = 1'b1;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    sb.push_back(exp);
    #1;
    chk({tag, "_stall0"}, w_t'(stallreq), w_t'(1'b1));
    c        = 0;
    found    = 1'b0;
    stall_ok = 1'b1;
    while (!found && c < 45) begin
      next_cycle();
      start      = 1'b0;
      signed_div = 1'($urandom);
      opdata1    = $urandom;
      opdata2    = $urandom;
      c++;
      #1;
      if (ready) found = 1'b1;
      else stall_ok = stall_ok & (stallreq === 1'b1);
    end
    chk({tag, "_lat"}, w_t'(c), w_t'(lat));
    chk({tag, "_busy"}, w_t'(stall_ok), w_t'(1'b1));
    want = (sb.size() > 0) ? sb.pop_front() : 64'd0;
    if (found) begin
      chk({tag, "_res"}, w_t'({hi_data, lo_data}), w_t'(want));
      chk({tag, "_we"}, w_t'({hi_we, lo_we, stallreq}), w_t'(3'b110));
    end
    next_cycle();
    #1;
    chk({tag, "_after"}, w_t'({ready, hi_we, lo_we, hi_data, lo_data}), w_t'(0));
  endtask

  initial begin : main
    logic        any_we;
    logic [31:0] a;
    logic [31:0] b;
    logic        sd;
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    #12;
    chk("reset_outs", w_t'({stallreq, ready, hi_we, lo_we, hi_data, lo_data}), w_t'(0));
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    run_div(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, "div_ovf");
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'd0}, "divu_ovf");
    run_div(1'b0, 32'h1234, 32'd0, 2, {32'h1234, 32'hFFFF_FFFF}, "divu_zero");
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 2, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, "div_zero_neg");

    for (int i = 0; i < 6; i++) begin
      sd = 1'($urandom);
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      run_div(sd, a, b, (b == 32'd0) ? 2 : 33, model(sd, a, b), "rand");
    end

    // Flush in cycle 10 of a divide
    start   = 1'b1;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    signed_div = 1'b0;
    any_we  = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      next_cycle();
      start = 1'b0;
      annul = (cyc == 10);
      #1;
      any_we = any_we | hi_we | lo_we | ready;
      if (cyc == 10) chk("annul_stall10", w_t'(stallreq), w_t'(1'b0));
      if (cyc == 11) chk("annul_idle11", w_t'(stallreq), w_t'(1'b0));
    end
    chk("annul_no_write", w_t'(any_we), w_t'(1'b0));
    next_cycle();
    run_div(1'b0, 32'd9, 32'd4, 33, {32'd1, 32'd2}, "after_annul");

    // Start with annul in IDLE is not accepted
    start = 1'b1;
    annul = 1'b1;
    #1;
    chk("annul_idle_stall", w_t'(stallreq), w_t'(1'b0));
    next_cycle();
    start = 1'b0;
    annul = 1'b0;
    #1;
    chk("annul_idle_noacc", w_t'(stallreq), w_t'(1'b0));

    // Annul during END does not cancel the write
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'h55;
    opdata2    = 32'd0;
    next_cycle();
    start = 1'b0;
    next_cycle();
    annul = 1'b1;
    #1;
    chk("annul_end_write", w_t'({ready, hi_we, lo_we, hi_data, lo_data}),
        w_t'({3'b111, 32'h55, 32'hFFFF_FFFF}));
    next_cycle();
    annul = 1'b0;

    // Reset in cycle 15 of a divide
    start   = 1'b1;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      next_cycle();
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk("rst_mid_outs", w_t'({stallreq, ready, hi_we, lo_we, hi_data, lo_data}), w_t'(0));
    next_cycle();
    next_cycle();
    resetn = 1'b1;
    any_we = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      next_cycle();
      #1;
      any_we = any_we | hi_we | lo_we | ready | stallreq;
    end
    chk("rst_no_write", w_t'(any_we), w_t'(1'b0));
    next_cycle();
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
